// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-master mem_reg arbiter.
package mem_arb_pkg;

  localparam int NUM_MASTERS = 2;

  typedef struct packed {
    logic vld;
    logic id;
    logic err;
  } tag_t;

  // Full-width unsigned compare; callers zero-extend to 64 bits.
  function automatic logic in_range(input logic [63:0] addr, input logic [63:0] mem_size);
    return addr < mem_size;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the master not granted last wins a tie.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   hs,
  output logic [NUM_MASTERS-1:0] gnt
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt = '0;
    if (req[0] && (!req[1] || last_grant_q)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
    last_grant_d = hs ? gnt[1] : last_grant_q;
  end

  // Reset value 1 lets master 0 win the first contested cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mem_reg_arbiter.sv
// Round-robin sequencer sharing one registered-read RAM port between two masters;
// fixed 2-cycle handshake-to-response latency, one access per clock.
module mem_reg_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_SIZE   = 4096,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic                  m0_req_we,
  input  logic [ADDR_WIDTH-1:0] m0_req_addr,
  input  logic [DATA_WIDTH-1:0] m0_req_wdata,
  output logic                  m0_rsp_valid,
  output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
  output logic                  m0_rsp_err,
  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic                  m1_req_we,
  input  logic [ADDR_WIDTH-1:0] m1_req_addr,
  input  logic [DATA_WIDTH-1:0] m1_req_wdata,
  output logic                  m1_rsp_valid,
  output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
  output logic                  m1_rsp_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [ADDR_WIDTH-1:0] mem_addw,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] gnt;
  logic                   hs;
  logic                   sel_we;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic                   sel_ok;

  logic                   mem_we_q,   mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_din_q,  mem_din_d;
  tag_t                   tag_p0_q,   tag_p0_d;
  tag_t                   tag_p1_q,   tag_p1_d;

  // No request is offered to the arbiter while reset is held.
  assign req = {m1_req_valid, m0_req_valid} & {NUM_MASTERS{rst_n}};
  assign hs  = |gnt;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .hs    (hs),
    .gnt   (gnt)
  );

  assign m0_req_ready = gnt[0];
  assign m1_req_ready = gnt[1];

  always_comb begin
    sel_we    = gnt[1] ? m1_req_we    : m0_req_we;
    sel_addr  = gnt[1] ? m1_req_addr  : m0_req_addr;
    sel_wdata = gnt[1] ? m1_req_wdata : m0_req_wdata;
    sel_ok    = in_range(64'(sel_addr), 64'(MEM_SIZE));

    mem_we_d   = hs && sel_we && sel_ok;
    mem_addr_d = hs ? sel_addr  : mem_addr_q;
    mem_din_d  = hs ? sel_wdata : mem_din_q;

    tag_p0_d.vld = hs;
    tag_p0_d.id  = gnt[1];
    tag_p0_d.err = hs && !sel_ok;
    tag_p1_d     = tag_p0_q;
  end

  // Issue stage (p0) and response stage (p1)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      tag_p0_q   <= '0;
      tag_p1_q   <= '0;
    end else begin
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      tag_p0_q   <= tag_p0_d;
      tag_p1_q   <= tag_p1_d;
    end
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_addw = mem_addr_q;
  assign mem_din  = mem_din_q;

  // The RAM word arrives alongside tag_p1; out-of-range responses carry zero.
  assign m0_rsp_valid = tag_p1_q.vld && !tag_p1_q.id;
  assign m1_rsp_valid = tag_p1_q.vld &&  tag_p1_q.id;
  assign m0_rsp_err   = m0_rsp_valid && tag_p1_q.err;
  assign m1_rsp_err   = m1_rsp_valid && tag_p1_q.err;
  assign m0_rsp_rdata = (m0_rsp_valid && !tag_p1_q.err) ? mem_dout : '0;
  assign m1_rsp_rdata = (m1_rsp_valid && !tag_p1_q.err) ? mem_dout : '0;

endmodule

// File: tb/tb_mem_reg_arbiter.sv
// Directed bench for mem_reg_arbiter with a behavioural read-before-write RAM.
module tb_mem_reg_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req_valid, m0_req_ready, m0_req_we;
  logic [31:0] m0_req_addr, m0_req_wdata;
  logic        m0_rsp_valid, m0_rsp_err;
  logic [31:0] m0_rsp_rdata;
  logic        m1_req_valid, m1_req_ready, m1_req_we;
  logic [31:0] m1_req_addr, m1_req_wdata;
  logic        m1_rsp_valid, m1_rsp_err;
  logic [31:0] m1_rsp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_addw, mem_din, mem_dout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ram [0:1023];

  mem_reg_arbiter #(.MEM_SIZE(4096), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0_req_valid (m0_req_valid),
    .m0_req_ready (m0_req_ready),
    .m0_req_we    (m0_req_we),
    .m0_req_addr  (m0_req_addr),
    .m0_req_wdata (m0_req_wdata),
    .m0_rsp_valid (m0_rsp_valid),
    .m0_rsp_rdata (m0_rsp_rdata),
    .m0_rsp_err   (m0_rsp_err),
    .m1_req_valid (m1_req_valid),
    .m1_req_ready (m1_req_ready),
    .m1_req_we    (m1_req_we),
    .m1_req_addr  (m1_req_addr),
    .m1_req_wdata (m1_req_wdata),
    .m1_rsp_valid (m1_rsp_valid),
    .m1_rsp_rdata (m1_rsp_rdata),
    .m1_rsp_err   (m1_rsp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_addw     (mem_addw),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: registered read of the old word, write in the same edge.
  initial begin
    for (int k = 0; k < 1024; k++) ram[k] = '0;
    mem_dout = '0;
  end
  always @(posedge clk) begin
    mem_dout <= ram[mem_addr[11:2]];
    if (mem_we) ram[mem_addw[11:2]] <= mem_din;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic v1, input logic we1, input logic [31:0] a1, input logic [31:0] d1);
    m0_req_valid = v0; m0_req_we = we0; m0_req_addr = a0; m0_req_wdata = d0;
    m1_req_valid = v1; m1_req_we = we1; m1_req_addr = a1; m1_req_wdata = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    // Reset state, including ready held low with a request present
    drive(1'b1, 1'b1, 32'h4, 32'h1234, 1'b1, 1'b0, 32'h8, 32'h0);
    #1;
    check("rst_rdy0", 32'(m0_req_ready), 32'(0));
    check("rst_rdy1", 32'(m1_req_ready), 32'(0));
    check("rst_rsp0", 32'(m0_rsp_valid), 32'(0));
    check("rst_rsp1", 32'(m1_rsp_valid), 32'(0));
    check("rst_we",   32'(mem_we), 32'(0));
    check("rst_addr", mem_addr, 32'h0);
    check("rst_din",  mem_din, 32'h0);
    check("rst_rdat", m0_rsp_rdata, 32'h0);
    tick();
    idle();
    rst_n = 1'b1;
    tick();

    // 1: m0 write 0xDEADBEEF @0x10
    drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("t1_rdy0", 32'(m0_req_ready), 32'(1));
    tick();
    idle();
    check("t1_we",   32'(mem_we), 32'(1));
    check("t1_addw", mem_addw, 32'h10);
    check("t1_din",  mem_din, 32'hDEADBEEF);
    check("t1_rsp_early", 32'(m0_rsp_valid), 32'(0));
    // 2: m1 reads @0x10 while the m0 ack is still in flight
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    check("t2_rdy1", 32'(m1_req_ready), 32'(1));
    tick();
    idle();
    check("t1_rsp0", 32'(m0_rsp_valid), 32'(1));
    check("t1_err0", 32'(m0_rsp_err), 32'(0));
    check("t1_rsp1_quiet", 32'(m1_rsp_valid), 32'(0));
    check("t2_we", 32'(mem_we), 32'(0));
    tick();
    check("t2_rsp1",  32'(m1_rsp_valid), 32'(1));
    check("t2_rdata", m1_rsp_rdata, 32'hDEADBEEF);
    check("t2_rsp0",  32'(m0_rsp_valid), 32'(0));
    check("t2_addr_hold", mem_addr, 32'h10);
    tick();
    check("t2_done", 32'(m1_rsp_valid), 32'(0));

    // 3: both masters continuously valid; m0 reads 0x10, m1 reads 0x0
    for (int i = 0; i < 7; i++) begin
      if (i < 6) drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
      else idle();
      #1;
      if (i < 6) begin
        check($sformatf("t3_rdy0_%0d", i), 32'(m0_req_ready), 32'((i % 2) == 0));
        check($sformatf("t3_rdy1_%0d", i), 32'(m1_req_ready), 32'((i % 2) == 1));
      end
      tick();
      if (i >= 1) begin
        check($sformatf("t3_rsp0_%0d", i - 1), 32'(m0_rsp_valid), 32'(((i - 1) % 2) == 0));
        check($sformatf("t3_rsp1_%0d", i - 1), 32'(m1_rsp_valid), 32'(((i - 1) % 2) == 1));
        if (((i - 1) % 2) == 0) check($sformatf("t3_dat0_%0d", i - 1), m0_rsp_rdata, 32'hDEADBEEF);
        else                    check($sformatf("t3_dat1_%0d", i - 1), m1_rsp_rdata, 32'h0);
      end
    end
    tick();
    check("t3_quiet0", 32'(m0_rsp_valid), 32'(0));
    check("t3_quiet1", 32'(m1_rsp_valid), 32'(0));

    // 4: out-of-range write @0x1000 (aliases word 0 in a 12-bit RAM index)
    drive(1'b1, 1'b1, 32'h1000, 32'h55AA55AA, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    idle();
    check("t4_we", 32'(mem_we), 32'(0));
    tick();
    check("t4_rsp0",  32'(m0_rsp_valid), 32'(1));
    check("t4_err0",  32'(m0_rsp_err), 32'(1));
    check("t4_rdata", m0_rsp_rdata, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    idle();
    tick();
    check("t4_rb_rsp", 32'(m0_rsp_valid), 32'(1));
    check("t4_rb_err", 32'(m0_rsp_err), 32'(0));
    check("t4_rb_dat", m0_rsp_rdata, 32'h0);

    // 5: back-to-back writes to 0x20, then a read
    drive(1'b1, 1'b1, 32'h20, 32'h11111111, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b1, 1'b1, 32'h20, 32'h22222222, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("t5_ack1", m0_rsp_rdata, 32'h0);
    tick();
    idle();
    check("t5_ack2_vld", 32'(m0_rsp_valid), 32'(1));
    check("t5_ack2", m0_rsp_rdata, 32'h11111111);
    tick();
    check("t5_rd_vld", 32'(m0_rsp_valid), 32'(1));
    check("t5_rd", m0_rsp_rdata, 32'h22222222);
    tick();

    // 6: reset while a read is in flight, with both masters requesting
    drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    check("t6_rdy0_rst", 32'(m0_req_ready), 32'(0));
    check("t6_rdy1_rst", 32'(m1_req_ready), 32'(0));
    tick();
    rst_n = 1'b1;
    check("t6_rsp0_a", 32'(m0_rsp_valid), 32'(0));
    check("t6_rsp1_a", 32'(m1_rsp_valid), 32'(0));
    #1;
    check("t6_rdy0", 32'(m0_req_ready), 32'(1));
    check("t6_rdy1", 32'(m1_req_ready), 32'(0));
    tick();
    idle();
    check("t6_rsp0_b", 32'(m0_rsp_valid), 32'(0));
    check("t6_rsp1_b", 32'(m1_rsp_valid), 32'(0));
    tick();
    check("t6_post_vld", 32'(m0_rsp_valid), 32'(1));
    check("t6_post_dat", m0_rsp_rdata, 32'h22222222);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
